// File: rtl/noc_pkg.sv
// Shared defaults, flit type and error-bit positions for the mesh router port logic.
package noc_pkg;
   localparam int DEF_FLIT_W  = 16;
   localparam int DEF_DEPTH   = 4;
   localparam int DEF_CREDITS = 4;

   typedef logic [DEF_FLIT_W-1:0] flit_t;

   localparam int ERR_W      = 3;
   localparam int ERR_IN_OVF = 0;
   localparam int ERR_CR_UNF = 1;
   localparam int ERR_CR_OVF = 2;
endpackage

// File: rtl/noc_credit_counter.sv
// Output-link credit counter: tracks free downstream slots and flags sticky
// underflow/overflow of the credit protocol.
module noc_credit_counter #(
   parameter int CREDITS = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic send_i,
   input  logic credit_i,
   output logic can_send_o,
   output logic unf_err_o,
   output logic ovf_err_o
);
   localparam int CW = $clog2(CREDITS + 1);
   localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

   logic [CW-1:0] cnt_p0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_p0    <= CRED_MAX;
         unf_err_o <= 1'b0;
         ovf_err_o <= 1'b0;
      end else begin
         // a send and a returned credit in the same cycle cancel out
         case ({send_i, credit_i})
            2'b10: begin
               if (cnt_p0 == '0) unf_err_o <= 1'b1;
               else              cnt_p0    <= cnt_p0 - CW'(1);
            end
            2'b01: begin
               if (cnt_p0 == CRED_MAX) ovf_err_o <= 1'b1;
               else                    cnt_p0    <= cnt_p0 + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign can_send_o = (cnt_p0 != '0);
endmodule

// File: rtl/noc_port_buffer.sv
// Per-port router flow control: input flit FIFO with credit return upstream,
// plus downstream credit tracking and sticky protocol-error flags.
module noc_port_buffer
   import noc_pkg::*;
#(
   parameter int FLIT_W  = DEF_FLIT_W,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int CREDITS = DEF_CREDITS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [FLIT_W-1:0] link_flit_i,
   input  logic              link_valid_i,
   output logic              link_credit_o,
   output logic [FLIT_W-1:0] deq_flit_o,
   output logic              deq_valid_o,
   input  logic              deq_ready_i,
   input  logic              out_send_i,
   input  logic              out_credit_i,
   output logic              out_can_send_o,
   output logic [ERR_W-1:0]  err_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [FLIT_W-1:0] mem [DEPTH];
   logic [PW-1:0]     head_p0, tail_p0;
   logic              empty, full, push, pop;
   logic              in_ovf_p0, credit_p1;
   logic              cr_unf, cr_ovf;

   assign empty = (head_p0 == tail_p0);
   assign full  = (head_p0[AW] != tail_p0[AW]) && (head_p0[AW-1:0] == tail_p0[AW-1:0]);
   assign pop   = !empty && deq_ready_i;
   // a pop frees the slot for a push arriving in the same cycle
   assign push  = link_valid_i && (!full || pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_p0   <= '0;
         tail_p0   <= '0;
         in_ovf_p0 <= 1'b0;
         credit_p1 <= 1'b0;
      end else begin
         if (pop)                    head_p0   <= head_p0 + PW'(1);
         if (push)                   tail_p0   <= tail_p0 + PW'(1);
         if (link_valid_i && !push)  in_ovf_p0 <= 1'b1;
         credit_p1 <= pop;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[tail_p0[AW-1:0]] <= link_flit_i;
   end

   // stage p1: registered credit return, one pulse per dequeued flit
   assign link_credit_o = credit_p1;
   assign deq_valid_o   = !empty;
   assign deq_flit_o    = empty ? '0 : mem[head_p0[AW-1:0]];

   noc_credit_counter #(
      .CREDITS(CREDITS)
   ) u_credit_counter (
      .clk       (clk),
      .rst       (rst),
      .send_i    (out_send_i),
      .credit_i  (out_credit_i),
      .can_send_o(out_can_send_o),
      .unf_err_o (cr_unf),
      .ovf_err_o (cr_ovf)
   );

   always_comb begin
      err_o             = '0;
      err_o[ERR_IN_OVF] = in_ovf_p0;
      err_o[ERR_CR_UNF] = cr_unf;
      err_o[ERR_CR_OVF] = cr_ovf;
   end
endmodule

// File: tb/tb_noc_port_buffer.sv
// Bench for noc_port_buffer: queue-based reference model compared every cycle,
// plus literal expectations for the directed scenarios.
module tb_noc_port_buffer;
   localparam int FLIT_W  = 16;
   localparam int DEPTH   = 4;
   localparam int CREDITS = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [FLIT_W-1:0] link_flit_i = '0;
   logic              link_valid_i = 1'b0;
   logic              link_credit_o;
   logic [FLIT_W-1:0] deq_flit_o;
   logic              deq_valid_o;
   logic              deq_ready_i = 1'b0;
   logic              out_send_i = 1'b0;
   logic              out_credit_i = 1'b0;
   logic              out_can_send_o;
   logic [2:0]        err_o;

   noc_port_buffer #(
      .FLIT_W(FLIT_W), .DEPTH(DEPTH), .CREDITS(CREDITS)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .link_flit_i   (link_flit_i),
      .link_valid_i  (link_valid_i),
      .link_credit_o (link_credit_o),
      .deq_flit_o    (deq_flit_o),
      .deq_valid_o   (deq_valid_o),
      .deq_ready_i   (deq_ready_i),
      .out_send_i    (out_send_i),
      .out_credit_i  (out_credit_i),
      .out_can_send_o(out_can_send_o),
      .err_o         (err_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   // reference model: flit queue, integer credit count, pending credit bit
   logic [FLIT_W-1:0] q[$];
   int                cnt_m;
   bit                cred_m;
   logic [2:0]        err_m;
   bit                pop_m;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q.delete();
         cnt_m  = CREDITS;
         cred_m = 1'b0;
         err_m  = 3'b000;
      end else begin
         pop_m = (q.size() > 0) && deq_ready_i;
         if (pop_m) void'(q.pop_front());
         if (link_valid_i) begin
            if (q.size() < DEPTH) q.push_back(link_flit_i);
            else                  err_m[0] = 1'b1;
         end
         cred_m = pop_m;
         if (out_send_i && !out_credit_i) begin
            if (cnt_m == 0) err_m[1] = 1'b1;
            else            cnt_m--;
         end else if (out_credit_i && !out_send_i) begin
            if (cnt_m == CREDITS) err_m[2] = 1'b1;
            else                  cnt_m++;
         end
      end
   end

   always @(negedge clk) if (link_credit_o === 1'b1) pulses++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      check("m_deq_valid", 32'(deq_valid_o), 32'(q.size() != 0));
      if (q.size() != 0) check("m_deq_flit", 32'(deq_flit_o), 32'(q[0]));
      else               check("m_deq_flit_zero", 32'(deq_flit_o), 32'h0);
      check("m_link_credit", 32'(link_credit_o), 32'(cred_m));
      check("m_can_send", 32'(out_can_send_o), 32'(cnt_m != 0));
      check("m_err", 32'(err_o), 32'(err_m));
   endtask

   // apply one cycle of inputs; compare against the model mid-cycle
   task automatic cyc(input logic v, input logic [FLIT_W-1:0] f, input logic r,
                      input logic s, input logic c);
      link_valid_i = v;
      link_flit_i  = f;
      deq_ready_i  = r;
      out_send_i   = s;
      out_credit_i = c;
      @(negedge clk);
      compare_model();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst          = 1'b0;
      link_valid_i = 1'b0;
      link_flit_i  = '0;
      deq_ready_i  = 1'b0;
      out_send_i   = 1'b0;
      out_credit_i = 1'b0;
      @(negedge clk);
      compare_model();
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   logic [FLIT_W-1:0] exp_a [4];
   int p0;

   initial begin
      exp_a[0] = 16'h0001; exp_a[1] = 16'h0002; exp_a[2] = 16'h0003; exp_a[3] = 16'h0004;
      @(posedge clk); #1;
      do_reset();
      check("rst_deq_valid", 32'(deq_valid_o), 32'h0);
      check("rst_deq_flit", 32'(deq_flit_o), 32'h0);
      check("rst_link_credit", 32'(link_credit_o), 32'h0);
      check("rst_can_send", 32'(out_can_send_o), 32'h1);
      check("rst_err", 32'(err_o), 32'h0);

      // fill with ready low
      for (int i = 0; i < 4; i++) cyc(1'b1, 16'(i + 1), 1'b0, 1'b0, 1'b0);
      check("fill_valid", 32'(deq_valid_o), 32'h1);
      check("fill_head", 32'(deq_flit_o), 32'h0001);
      check("fill_err", 32'(err_o), 32'h0);
      idle();
      check("fill_head_stable", 32'(deq_flit_o), 32'h0001);

      // overflow push, then drain
      cyc(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
      check("ovf_err", 32'(err_o), 32'h1);
      p0 = pulses;
      for (int i = 0; i < 4; i++) begin
         check("drain_flit", 32'(deq_flit_o), 32'(exp_a[i]));
         cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
         check("drain_credit", 32'(link_credit_o), 32'h1);
      end
      idle();
      check("drain_empty", 32'(deq_valid_o), 32'h0);
      check("drain_credit_off", 32'(link_credit_o), 32'h0);
      check("drain_pulses", 32'(pulses - p0), 32'd4);

      // simultaneous push and pop while full
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1'b1, 16'(i + 1), 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 16'h0005, 1'b1, 1'b0, 1'b0);
      check("pp_err", 32'(err_o), 32'h0);
      check("pp_head", 32'(deq_flit_o), 32'h0002);
      cyc(1'b1, 16'h0006, 1'b0, 1'b0, 1'b0);
      check("pp_still_full", 32'(err_o), 32'h1);
      for (int i = 0; i < 4; i++) begin
         check("pp_flit", 32'(deq_flit_o), 32'(i + 2));
         cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      end
      check("pp_empty", 32'(deq_valid_o), 32'h0);

      // credit underflow
      do_reset();
      for (int i = 0; i < 4; i++) begin
         check("send_can", 32'(out_can_send_o), 32'h1);
         cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
      end
      check("send_exhaust", 32'(out_can_send_o), 32'h0);
      check("send_no_err", 32'(err_o), 32'h0);
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
      check("unf_err", 32'(err_o), 32'h2);
      check("unf_can", 32'(out_can_send_o), 32'h0);
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
      check("unf_recover", 32'(out_can_send_o), 32'h1);
      check("unf_sticky", 32'(err_o), 32'h2);

      // credit overflow, then both at zero
      do_reset();
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
      check("cov_err", 32'(err_o), 32'h4);
      for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
      check("cov_cnt1", 32'(out_can_send_o), 32'h1);
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
      check("cov_cnt0", 32'(out_can_send_o), 32'h0);
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
      check("both_zero_can", 32'(out_can_send_o), 32'h0);
      check("both_zero_err", 32'(err_o), 32'h4);

      // both at full credit count
      do_reset();
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
      check("both_full_err", 32'(err_o), 32'h0);
      for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
      check("both_full_cnt", 32'(out_can_send_o), 32'h0);

      // reset mid-operation with pending credit pulse
      do_reset();
      cyc(1'b1, 16'h00A1, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 16'h00A2, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 16'h00A3, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 16'h00A4, 1'b1, 1'b0, 1'b0);
      check("pre_rst_credit", 32'(link_credit_o), 32'h1);
      check("pre_rst_can", 32'(out_can_send_o), 32'h1);
      check("pre_rst_head", 32'(deq_flit_o), 32'h00A2);
      p0 = pulses;
      rst = 1'b0;
      link_valid_i = 1'b0;
      deq_ready_i  = 1'b0;
      #1;
      check("async_valid", 32'(deq_valid_o), 32'h0);
      check("async_can", 32'(out_can_send_o), 32'h1);
      check("async_err", 32'(err_o), 32'h0);
      check("async_credit", 32'(link_credit_o), 32'h0);
      @(negedge clk);
      compare_model();
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle();
      idle();
      check("no_credit_after_rst", 32'(pulses - p0), 32'd0);
      check("post_rst_empty", 32'(deq_valid_o), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
